// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame/oversample
// constants common to transmitter, receiver and baud generator.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

  // Odd sense simply inverts the even-parity mismatch.
  function automatic logic parity_mismatch(input logic data_xor, input logic pbit, input logic odd);
    return data_xor ^ pbit ^ odd;
  endfunction

endpackage

// File: rtl/uart_sipo.sv
// Serial-in/parallel-out word register for the UART receiver; serial data enters
// the MSB and moves right, so an LSB-first stream lands in natural bit order.
module uart_sipo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] par_out
);

  logic [DATA_BITS-1:0] shreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else if (shift_en) begin
      shreg_q <= {serial_in, shreg_q[DATA_BITS-1:1]};
    end else begin
      shreg_q <= shreg_q;
    end
  end

  assign par_out = shreg_q;

endmodule

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: 2-flop line synchronizer, start validation, mid-bit
// sampling and framing check. Optional parity bit enabled by `define UART_RX_PARITY_EN.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = PARITY;
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif

  if (DATA_BITS < 5 || DATA_BITS > 8 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_sipo: unsupported parameter combination");
  end

  logic                 sync1_q;
  logic                 rx_s_q;
  uart_state_e          state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 rx_busy_q;
  logic                 shift_en_s;
  logic [DATA_BITS-1:0] shreg_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_pend_q;
  logic                 parity_err_q;
`endif

  // Idle-high reset value keeps a reset release from looking like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  assign shift_en_s = sample_tick && (state_q == DATA) && (tick_cnt_q == TICK_LAST);

  uart_sipo #(.DATA_BITS(DATA_BITS)) u_sipo (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en_s),
    .serial_in (rx_s_q),
    .par_out   (shreg_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_q   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (sample_tick) begin
        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        case (state_q)
          IDLE: begin
            tick_cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= START;
              rx_busy_q <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt_q == TICK_MID) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              if (!rx_s_q) begin
                state_q <= DATA;
              end else begin
                state_q   <= IDLE;
                rx_busy_q <= 1'b0;
              end
            end
          end
          DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= AFTER_DATA;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              par_pend_q <= parity_mismatch(^shreg_s, rx_s_q, PARITY_ODD != 0);
              state_q    <= STOP;
            end
          end
`endif
          STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              if (rx_s_q) begin
                rx_data_q  <= shreg_s;
                rx_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= par_pend_q;
`endif
                state_q    <= IDLE;
                rx_busy_q  <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= WAIT_IDLE;
              end
            end
          end
          // A held-low line (break) must return high before a new start is accepted.
          WAIT_IDLE: begin
            tick_cnt_q <= '0;
            if (rx_s_q) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end
          end
          default: begin
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            rx_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: tick-level frame model compared every clock,
// plus literal checks of directed scenarios. Honors `define UART_RX_PARITY_EN.
module tb_uart_rx_sipo;

  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int STOP_OFF = OS / 2 + OS * (DB + 1 + PAR);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, rx_busy;

  uart_rx_sipo #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int gap_max  = 0;
  logic [7:0] obs_data[$];
`ifdef UART_RX_PARITY_EN
  logic       obs_perr[$];
`endif

  // model: what each tick saw, and frame-level bookkeeping
  bit         hist[$];
  int         m_mode;   // 0 idle, 1 in frame, 2 waiting for line high
  int         m_start;
  logic       exp_valid, exp_ferr, exp_perr, exp_busy;
  logic [7:0] exp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0; exp_busy = 1'b0;
    exp_data  = 8'h00;
    m_mode    = 0;
  endtask

  task automatic model_step(input bit v);
    int t, off;
    logic [7:0] d;
    bit pb;
    hist.push_back(v);
    t = hist.size() - 1;
    case (m_mode)
      0: if (!v) begin m_mode = 1; m_start = t; exp_busy = 1'b1; end
      1: begin
        off = t - m_start;
        if (off == OS / 2 && v) begin
          m_mode = 0; exp_busy = 1'b0;
        end else if (off == STOP_OFF) begin
          for (int i = 0; i < DB; i++) d[i] = hist[m_start + OS / 2 + OS * (i + 1)];
          pb = hist[m_start + OS / 2 + OS * (DB + 1)];
          if (v) begin
            exp_valid = 1'b1; exp_data = d;
            exp_perr  = (PAR != 0) ? ((^d) ^ pb) : 1'b0;
            m_mode = 0; exp_busy = 1'b0;
          end else begin
            exp_ferr = 1'b1; m_mode = 2;
          end
        end
      end
      default: if (v) begin m_mode = 0; exp_busy = 1'b0; end
    endcase
  endtask

  always @(negedge clk) begin
    chk("rx_valid", rx_valid, exp_valid);
    chk("frame_err", frame_err, exp_ferr);
    chk("parity_err", parity_err, exp_perr);
    chk("rx_data", rx_data, exp_data);
    chk("rx_busy", rx_busy, exp_busy);
    if (rx_valid === 1'b1) begin
      n_valid++;
      obs_data.push_back(rx_data);
`ifdef UART_RX_PARITY_EN
      obs_perr.push_back(parity_err);
`endif
    end
    if (frame_err === 1'b1) n_ferr++;
  end

  // one oversample tick that sees line value v once it has crossed the synchronizer
  task automatic do_tick(input bit v);
    rx_in = v;
    repeat (3 + $urandom_range(0, gap_max)) @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    sample_tick = 1'b0;
    #1;
    exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
  endtask

  task automatic send_bit(input bit v);
    repeat (OS) do_tick(v);
  endtask

  task automatic idle(input int n);
    repeat (n) do_tick(1'b1);
  endtask

  // bad_par flips the parity bit away from even parity
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (PAR != 0) send_bit((^d) ^ bad_par);
    send_bit(stop);
  endtask

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0;
    logic [7:0] d5a;
    rst_n = 1'b0; sample_tick = 1'b0; rx_in = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("reset_data", rx_data, 32'h0);
    chk("reset_busy", rx_busy, 32'h0);
    idle(4);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    chk("a5_pulses", n_valid - v0, 32'd1);
    chk("a5_data", rx_data, 32'hA5);
    chk("a5_ferr", n_ferr - f0, 32'd0);
    chk("a5_busy", rx_busy, 32'h0);

    v0 = n_valid; f0 = n_ferr;
    repeat (3) do_tick(1'b0);
    idle(20);
    chk("glitch_valid", n_valid - v0, 32'd0);
    chk("glitch_ferr", n_ferr - f0, 32'd0);
    chk("glitch_data", rx_data, 32'hA5);
    chk("glitch_busy", rx_busy, 32'h0);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) do_tick(1'b0);
    chk("break_ferr", n_ferr - f0, 32'd1);
    chk("break_valid", n_valid - v0, 32'd0);
    chk("break_data", rx_data, 32'hA5);
    chk("break_busy_low_line", rx_busy, 32'h1);
    idle(3);
    chk("break_busy_released", rx_busy, 32'h0);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(4);
    chk("zerogap_pulses", n_valid - v0, 32'd2);
    chk("zerogap_ferr", n_ferr - f0, 32'd0);
    if (obs_data.size() >= 2) begin
      chk("zerogap_first", obs_data[obs_data.size() - 2], 32'h00);
      chk("zerogap_second", obs_data[obs_data.size() - 1], 32'hFF);
    end else begin
      chk("zerogap_obs", obs_data.size(), 32'd2);
    end

    v0 = n_valid; f0 = n_ferr;
    d5a = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d5a[i]);
    repeat (OS / 2) do_tick(d5a[4]);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_data", rx_data, 32'h0);
    chk("midreset_busy", rx_busy, 32'h0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(4);
    chk("after_reset_pulses", n_valid - v0, 32'd1);
    chk("after_reset_data", rx_data, 32'h81);
    chk("after_reset_ferr", n_ferr - f0, 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    chk("par_bad_data", rx_data, 32'h07);
    chk("par_bad_flag", obs_perr[obs_perr.size() - 1], 32'h1);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
    chk("par_good_flag", obs_perr[obs_perr.size() - 1], 32'h0);
`endif

    gap_max = 4;
    repeat (20) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 7)) do_tick(1'b0);
      idle($urandom_range(0, 12));
    end
    idle(200);
    chk("random_end_busy", rx_busy, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
